// File: rtl/definitions_pkg.sv
// Shared control-unit definitions: major-cycle encodings and sequencer defaults.
// Pure declarations; no logic, no latency, no flow control.
package definitions_pkg;

   localparam int DATA_WIDTH_DEFAULT = 16;
   localparam int T_STEPS_DEFAULT    = 4;
   localparam int OP_FIELD_LSB       = DATA_WIDTH_DEFAULT - 4;

   localparam logic [1:0] CYCLE_FETCH     = 2'b00;
   localparam logic [1:0] CYCLE_INDIRECT  = 2'b01;
   localparam logic [1:0] CYCLE_EXECUTE   = 2'b10;
   localparam logic [1:0] CYCLE_INTERRUPT = 2'b11;

   typedef enum logic [1:0] {
      CYC_FETCH     = CYCLE_FETCH,
      CYC_INDIRECT  = CYCLE_INDIRECT,
      CYC_EXECUTE   = CYCLE_EXECUTE,
      CYC_INTERRUPT = CYCLE_INTERRUPT
   } cycle_e;

   // Register-reference / IO opcode: never takes an operand cycle.
   localparam logic [2:0] OP_REGREF = 3'b111;

endpackage

// File: rtl/cycle_sequencer_timing_counter.sv
// One-hot timing-step ring; clear wins over advance, hold freezes the ring.
// Registered output, one step per clock when advancing; stalls while hold_i is high.
module timing_counter
   import definitions_pkg::*;
#(
   parameter int T_STEPS = T_STEPS_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               hold_i,
   input  logic               advance_i,
   output logic [T_STEPS-1:0] t_step_o
);

   localparam logic [T_STEPS-1:0] STEP0 = T_STEPS'(1);

   logic [T_STEPS-1:0] step_q, step_d;

   always_comb begin
      step_d = step_q;
      if (clear_i) begin
         step_d = STEP0;
      end else if (advance_i && !hold_i) begin
         step_d = {step_q[T_STEPS-2:0], step_q[T_STEPS-1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q <= STEP0;
      end else begin
         step_q <= step_d;
      end
   end

   assign t_step_o = step_q;

endmodule

// File: rtl/cycle_sequencer.sv
// Major-cycle (F/R) and timing-step sequencer with run flip-flop, halt and interrupt entry.
// State registered, mem_req/cycle_end combinational; stalls at MEM_STEP until mem_ready.
module cycle_sequencer
   import definitions_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int T_STEPS    = T_STEPS_DEFAULT,
   parameter int MEM_STEP   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt,
   input  logic               mem_ready,
   input  logic [2:0]         ir_op,
   input  logic               ir_ind,
   input  logic               irq,
   input  logic               ien,
   output logic               running,
   output logic [1:0]         cycle,
   output logic [T_STEPS-1:0] t_step,
   output logic               mem_req,
   output logic               cycle_end,
   output logic               irq_ack
);

   if (T_STEPS < 3 || T_STEPS > 8) begin : g_bad_steps
      $error("cycle_sequencer: T_STEPS must be within 3..8");
   end
   if (MEM_STEP < 1 || MEM_STEP > T_STEPS - 2) begin : g_bad_mem_step
      $error("cycle_sequencer: MEM_STEP must satisfy 0 < MEM_STEP < T_STEPS-1");
   end
   if (DATA_WIDTH < 4) begin : g_bad_width
      $error("cycle_sequencer: DATA_WIDTH too narrow for the opcode field");
   end

   logic   running_q, running_d;
   cycle_e cycle_q, cycle_d;
   logic   halt_pend_q, halt_pend_d;
   logic   irq_ack_q, irq_ack_d;
   logic   stall;

   // The ring wraps to step 0 on its own; clearing at cycle_end also covers halt.
   assign stall = mem_req & ~mem_ready;

   timing_counter #(
      .T_STEPS (T_STEPS)
   ) u_timing (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (cycle_end),
      .hold_i    (stall),
      .advance_i (running_q),
      .t_step_o  (t_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         running_q   <= 1'b0;
         cycle_q     <= CYC_FETCH;
         halt_pend_q <= 1'b0;
         irq_ack_q   <= 1'b0;
      end else begin
         running_q   <= running_d;
         cycle_q     <= cycle_d;
         halt_pend_q <= halt_pend_d;
         irq_ack_q   <= irq_ack_d;
      end
   end

   always_comb begin
      running_d   = running_q;
      cycle_d     = cycle_q;
      halt_pend_d = halt_pend_q;
      irq_ack_d   = 1'b0;
      if (!running_q) begin
         running_d   = start & ~halt;
         halt_pend_d = 1'b0;
         cycle_d     = CYC_FETCH;
      end else begin
         if (halt) begin
            halt_pend_d = 1'b1;
         end
         if (cycle_end) begin
            irq_ack_d = (cycle_q == CYC_INTERRUPT);
            case (cycle_q)
               CYC_FETCH: begin
                  if (ir_op == OP_REGREF) begin
                     cycle_d = (irq & ien) ? CYC_INTERRUPT : CYC_FETCH;
                  end else if (ir_ind) begin
                     cycle_d = CYC_INDIRECT;
                  end else begin
                     cycle_d = CYC_EXECUTE;
                  end
               end
               CYC_INDIRECT: cycle_d = CYC_EXECUTE;
               CYC_EXECUTE:  cycle_d = (irq & ien) ? CYC_INTERRUPT : CYC_FETCH;
               default:      cycle_d = CYC_FETCH;
            endcase
            // A halt seen during this cycle stops at its boundary; irq_ack still fires.
            if (halt_pend_q) begin
               running_d   = 1'b0;
               halt_pend_d = 1'b0;
               cycle_d     = CYC_FETCH;
            end
         end
      end
   end

   always_comb begin
      mem_req   = running_q & t_step[MEM_STEP];
      cycle_end = running_q & t_step[T_STEPS-1];
   end

   assign running = running_q;
   assign cycle   = cycle_q;
   assign irq_ack = irq_ack_q;

endmodule
